// File: rtl/ysyx_23060236_lsu_axi_master.sv
// AXI4-lite initiator for LSU loads/stores with byte-lane alignment and load extension.
// Latency: zero-wait load completes 3 cycles after acceptance; misaligned/illegal requests complete next cycle.
// Backpressure: one request in flight (req_ready low while busy); AXI valids held until handshake; response is never stalled.
module ysyx_23060236_lsu_axi_master #(
    parameter logic RESP_CHECK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [31:0] awaddr_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_W,
        S_B,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        req_ready_q, req_ready_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        misalign;
    logic [3:0]  strb_base;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;

    // Request legality and the unshifted byte-enable pattern for the requested size
    always_comb begin
        misalign  = 1'b0;
        strb_base = 4'b0000;
        case (req_size_i)
            2'd0: strb_base = 4'b0001;
            2'd1: begin
                strb_base = 4'b0011;
                misalign  = req_addr_i[0];
            end
            2'd2: begin
                strb_base = 4'b1111;
                misalign  = (req_addr_i[1:0] != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

    // Bring the addressed lanes of the read beat down to bit 0, then sign/zero extend
    always_comb begin
        rd_shift = rdata_i >> {off_q, 3'b000};
        rd_ext   = rd_shift;
        case (size_q)
            2'd0: rd_ext = uns_q ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1: rd_ext = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // Next-state and registered-output computation; response fields default to an idle pulse
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        req_ready_d = req_ready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;

        case (state_q)
            // ERR only holds the error pulse; it accepts a new request just like IDLE
            S_IDLE, S_ERR: begin
                state_d = S_IDLE;
                if (req_valid_i && req_ready_q) begin
                    off_d  = req_addr_i[1:0];
                    size_d = req_size_i;
                    uns_d  = req_unsigned_i;
                    if (misalign) begin
                        state_d     = S_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_wen_i) begin
                        state_d     = S_W;
                        req_ready_d = 1'b0;
                        awaddr_d    = {req_addr_i[31:2], 2'b00};
                        awvalid_d   = 1'b1;
                        wvalid_d    = 1'b1;
                        wdata_d     = req_wdata_i << {req_addr_i[1:0], 3'b000};
                        wstrb_d     = strb_base << req_addr_i[1:0];
                        aw_done_d   = 1'b0;
                        w_done_d    = 1'b0;
                    end else begin
                        state_d     = S_AR;
                        req_ready_d = 1'b0;
                        araddr_d    = {req_addr_i[31:2], 2'b00};
                        arvalid_d   = 1'b1;
                    end
                end
            end
            S_AR: begin
                if (arvalid_q && arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (rvalid_i && rready_q) begin
                    rready_d    = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rd_ext;
                    rsp_err_d   = RESP_CHECK && (rresp_i != 2'b00);
                end
            end
            // AW and W retire independently; B is entered once both have handshaken
            S_W: begin
                if (awvalid_q && awready_i) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready_i) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d   = S_B;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_B: begin
                if (bvalid_i && bready_q) begin
                    bready_d    = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RESP_CHECK && (bresp_i != 2'b00);
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            req_ready_q <= 1'b1;
            araddr_q    <= 32'd0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= 32'd0;
            awvalid_q   <= 1'b0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            req_ready_q <= req_ready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign araddr_o    = araddr_q;
    assign arvalid_o   = arvalid_q;
    assign rready_o    = rready_q;
    assign awaddr_o    = awaddr_q;
    assign awvalid_o   = awvalid_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign wvalid_o    = wvalid_q;
    assign bready_o    = bready_q;

endmodule
